// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divide sequencer; stalls F/D/E while busy, pulses valid_o with HI/LO.
// Optional DIV_EARLY_EXIT_EN: finishes in one cycle on divide-by-zero or |a| < |b|.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dbz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz_o;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_last;

  assign w_accept = (r_state == S_IDLE) && start_i && !flush_i;
  assign w_a_neg  = signed_i && a_i[WIDTH-1];
  assign w_b_neg  = signed_i && b_i[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a_i : a_i;
  assign w_b_mag  = w_b_neg ? -b_i : b_i;
  assign w_b_zero = (b_i == '0);

  // Partial remainder can reach 2*divisor-1, so the shifted value needs one extra bit.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_div});
  assign w_diff    = w_shift[WIDTH-1:0] - r_div;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_a     <= a_i;
            r_dbz   <= w_b_zero;
            r_state <= S_BUSY;
`ifdef DIV_EARLY_EXIT_EN
            if (w_b_zero || (w_a_mag < w_b_mag)) begin
              r_hi    <= a_i;
              r_lo    <= w_b_zero ? '1 : '0;
              r_dbz_o <= w_b_zero;
              r_state <= S_DONE;
            end
`endif
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              // Divide-by-zero reports the raw dividend, not the sign-fixed remainder.
              r_hi    <= r_dbz ? r_a : w_r_fix;
              r_lo    <= r_dbz ? '1 : w_q_fix;
              r_dbz_o <= r_dbz;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_o = !flush_i && ((r_state == S_BUSY) || ((r_state == S_IDLE) && start_i));
  assign valid_o = (r_state == S_DONE) && !flush_i;
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;
  assign dbz_o   = r_dbz_o;

endmodule
